// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, FSM state
// encodings, ALU operation codes and the per-state control-word payload.
package mips_ctrl_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned ALU_CODE_W = 3;

  // Instruction opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // ALU operation codes
  localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 3'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 3'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_OR    = 3'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_AND   = 3'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_LUI   = 3'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_RTYPE = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JAL_WB   = 4'd12,
    S_ERROR    = 4'd15
  } state_t;

  // Datapath control word produced by the FSM decode each cycle
  typedef struct packed {
    logic                  pc_write;
    logic                  pc_write_eq;
    logic                  pc_write_ne;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  mem_to_reg;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_source;
    logic [ALU_CODE_W-1:0] alu_op;
    logic                  illegal_op;
  } ctrl_t;

  // States that issue a memory access and may stall on mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // ALU operation for the immediate-format arithmetic/logic instructions
  function automatic logic [ALU_CODE_W-1:0] imm_alu_code(input logic [OP_W-1:0] opcode);
    case (opcode)
      OP_ORI:  return ALU_OR;
      OP_ANDI: return ALU_AND;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter. Counts consecutive waiting cycles and flags
// expiry when a further wait is requested after MAX_WAIT tolerated waits.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset
//   waiting - a memory access is stalled this cycle
//   clear   - restart the count (FSM changes state this cycle)
//   expired - combinational: count has reached MAX_WAIT and still waiting
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count;

  // Saturating count of stalled cycles in the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting && (count != MAX_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A ready response in the same cycle wins because waiting is then low
  assign expired = waiting && (count == MAX_CNT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: FETCH/DECODE/execute FSM driving the
// datapath control strobes, with memory wait-state timeout.
// Optional feature: define MULTICYCLE_CONTROL_JAL_EN to add JAL (op 0x03).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   op                    - instruction opcode field
//   mem_ready             - memory access completes this cycle
//   pc_write..link        - single-bit datapath control strobes
//   alu_src_b, pc_source  - 2-bit mux selects
//   alu_op                - ALU operation (7 = funct decode)
//   state                 - current FSM state (debug)
//   illegal_op            - unknown opcode seen in DECODE
//   mem_timeout           - memory wait limit exceeded, FSM enters ERROR
// Outputs are a decode of the registered state (and mem_ready in FETCH),
// forced to 0 while reset is high.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_eq,
  output logic               pc_write_ne,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic               link,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic               mem_timeout
);

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op_q;
  ctrl_t           ctrl;
  ctrl_t           ctrl_o;
  logic            waiting;
  logic            clear;
  logic            expired;
`ifdef MULTICYCLE_CONTROL_JAL_EN
  logic            link_c;
`endif

  // State register and opcode latch (captured while leaving DECODE)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= op;
      end
    end
  end

  assign waiting = is_mem_state(state_q) && !mem_ready;
  assign clear   = (state_d != state_q);

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .clear  (clear),
    .expired(expired)
  );

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
`ifdef MULTICYCLE_CONTROL_JAL_EN
    link_c  = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (expired) begin
          state_d = S_ERROR;
        end else if (mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is dispatched
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
        case (op)
          OP_RTYPE:                         state_d = S_R_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_JAL_EN
          OP_JAL:                           state_d = S_JAL_WB;
`endif
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        if (expired) begin
          state_d = S_ERROR;
        end else if (mem_ready) begin
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        if (expired) begin
          state_d = S_ERROR;
        end else if (mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
        state_d        = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_op      = ALU_SUB;
        ctrl.pc_source   = 2'b01;
        ctrl.pc_write_eq = (op_q == OP_BEQ);
        ctrl.pc_write_ne = (op_q == OP_BNE);
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        state_d        = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = imm_alu_code(op_q);
        state_d        = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
`ifdef MULTICYCLE_CONTROL_JAL_EN
      S_JAL_WB: begin
        // Return address (PC) written to $31 while jumping
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        link_c         = 1'b1;
        state_d        = S_FETCH;
      end
`endif
      S_ERROR: begin
        state_d = S_ERROR;
      end
      // Unused encodings are treated as corruption and parked in ERROR
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  // Reset suppresses every strobe, including mid-instruction aborts
  assign ctrl_o = reset ? '0 : ctrl;

  assign pc_write    = ctrl_o.pc_write;
  assign pc_write_eq = ctrl_o.pc_write_eq;
  assign pc_write_ne = ctrl_o.pc_write_ne;
  assign i_or_d      = ctrl_o.i_or_d;
  assign mem_read    = ctrl_o.mem_read;
  assign mem_write   = ctrl_o.mem_write;
  assign ir_write    = ctrl_o.ir_write;
  assign mem_to_reg  = ctrl_o.mem_to_reg;
  assign reg_dst     = ctrl_o.reg_dst;
  assign reg_write   = ctrl_o.reg_write;
  assign alu_src_a   = ctrl_o.alu_src_a;
  assign alu_src_b   = ctrl_o.alu_src_b;
  assign pc_source   = ctrl_o.pc_source;
  assign alu_op      = ALUOP_W'(ctrl_o.alu_op);
  assign illegal_op  = ctrl_o.illegal_op;
  assign state       = reset ? 4'd0 : STATE_W'(state_q);
  assign mem_timeout = expired && !reset;

`ifdef MULTICYCLE_CONTROL_JAL_EN
  assign link = link_c && !reset;
`else
  assign link = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with MAX_WAIT=4. The stimulus process
// pushes the hand-derived expected output vector for each cycle into a queue;
// a monitor pops and compares on the falling edge.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_eq, pc_write_ne, i_or_d;
  logic       mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, link;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;

  multicycle_control #(
    .ALUOP_W (3),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_write_eq(pc_write_eq),
    .pc_write_ne(pc_write_ne),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .link       (link),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .alu_op     (alu_op),
    .state      (state),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_eq, pc_write_ne, i_or_d;
    logic       mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, link;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       illegal_op, mem_timeout;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  done    = 1'b0;
  logic  drained = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vectors, one per FSM state
  function automatic obs_t e_zero();
    obs_t e = '0;
    return e;
  endfunction
  function automatic obs_t e_fetch(input logic rdy, input logic tmo);
    obs_t e = '0;
    e.st = 4'd0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
    e.ir_write = rdy; e.pc_write = rdy; e.mem_timeout = tmo;
    return e;
  endfunction
  function automatic obs_t e_decode(input logic ill);
    obs_t e = '0;
    e.st = 4'd1; e.alu_src_b = 2'b11; e.illegal_op = ill;
    return e;
  endfunction
  function automatic obs_t e_memaddr();
    obs_t e = '0;
    e.st = 4'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    return e;
  endfunction
  function automatic obs_t e_memrd();
    obs_t e = '0;
    e.st = 4'd3; e.i_or_d = 1'b1; e.mem_read = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_memwb();
    obs_t e = '0;
    e.st = 4'd4; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_memwr();
    obs_t e = '0;
    e.st = 4'd5; e.i_or_d = 1'b1; e.mem_write = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_rexec();
    obs_t e = '0;
    e.st = 4'd6; e.alu_src_a = 1'b1; e.alu_op = 3'd7;
    return e;
  endfunction
  function automatic obs_t e_rwb();
    obs_t e = '0;
    e.st = 4'd7; e.reg_write = 1'b1; e.reg_dst = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_branch(input logic ne);
    obs_t e = '0;
    e.st = 4'd8; e.alu_src_a = 1'b1; e.alu_op = 3'd1; e.pc_source = 2'b01;
    e.pc_write_eq = ~ne; e.pc_write_ne = ne;
    return e;
  endfunction
  function automatic obs_t e_jump();
    obs_t e = '0;
    e.st = 4'd9; e.pc_write = 1'b1; e.pc_source = 2'b10;
    return e;
  endfunction
  function automatic obs_t e_iexec(input logic [2:0] alu);
    obs_t e = '0;
    e.st = 4'd10; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = alu;
    return e;
  endfunction
  function automatic obs_t e_iwb();
    obs_t e = '0;
    e.st = 4'd11; e.reg_write = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_jalwb();
    obs_t e = '0;
    e.st = 4'd12; e.reg_write = 1'b1; e.link = 1'b1; e.pc_write = 1'b1;
    e.pc_source = 2'b10;
    return e;
  endfunction
  function automatic obs_t e_error();
    obs_t e = '0;
    e.st = 4'd15;
    return e;
  endfunction

  // One cycle of stimulus with reset low; expectation queued for the monitor
  task automatic cyc(input logic [5:0] o, input logic r, input obs_t e, input string n);
    reset = 1'b0; op = o; mem_ready = r;
    exp_q.push_back(e); name_q.push_back(n);
    @(posedge clk); #1;
  endtask

  // One cycle with reset high
  task automatic rcyc(input logic r, input string n);
    reset = 1'b1; mem_ready = r;
    exp_q.push_back(e_zero()); name_q.push_back(n);
    @(posedge clk); #1;
  endtask

  // Monitor: compares every cycle that has a queued expectation
  always @(negedge clk) begin
    obs_t  got;
    obs_t  e;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      got = {state, pc_write, pc_write_eq, pc_write_ne, i_or_d,
             mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, link,
             alu_src_b, pc_source, alu_op, illegal_op, mem_timeout};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %07h (state %0d) expected %07h (state %0d)",
                 n, got, got.st, e, e.st);
      end
    end else if (done && !drained) begin
      n_tests++;
      drained <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] iops [4];
    logic [2:0] ialu [4];
    iops[0] = 6'h08; ialu[0] = 3'd0;
    iops[1] = 6'h0D; ialu[1] = 3'd2;
    iops[2] = 6'h0C; ialu[2] = 3'd3;
    iops[3] = 6'h0F; ialu[3] = 3'd4;

    reset = 1'b1; op = 6'h00; mem_ready = 1'b1;
    @(posedge clk); #1;
    rcyc(1'b1, "reset0");
    rcyc(1'b0, "reset1");

    // LW, no waits; op changed after DECODE must not alter the path
    cyc(6'h23, 1'b1, e_fetch(1'b1, 1'b0), "lw_fetch");
    cyc(6'h23, 1'b1, e_decode(1'b0),      "lw_decode");
    cyc(6'h2B, 1'b1, e_memaddr(),         "lw_addr_latched");
    cyc(6'h00, 1'b1, e_memrd(),           "lw_rd");
    cyc(6'h00, 1'b1, e_memwb(),           "lw_wb");

    // BEQ / BNE with the opposite opcode presented during BRANCH
    cyc(6'h04, 1'b1, e_fetch(1'b1, 1'b0), "beq_fetch");
    cyc(6'h04, 1'b1, e_decode(1'b0),      "beq_decode");
    cyc(6'h05, 1'b1, e_branch(1'b0),      "beq_branch");
    cyc(6'h05, 1'b1, e_fetch(1'b1, 1'b0), "bne_fetch");
    cyc(6'h05, 1'b1, e_decode(1'b0),      "bne_decode");
    cyc(6'h04, 1'b1, e_branch(1'b1),      "bne_branch");

    // SW with three wait states in MEM_WR
    cyc(6'h2B, 1'b1, e_fetch(1'b1, 1'b0), "sw_fetch");
    cyc(6'h2B, 1'b1, e_decode(1'b0),      "sw_decode");
    cyc(6'h2B, 1'b1, e_memaddr(),         "sw_addr");
    for (int i = 0; i < 3; i++) cyc(6'h2B, 1'b0, e_memwr(), "sw_wr_wait");
    cyc(6'h2B, 1'b1, e_memwr(),           "sw_wr_done");

    // Fetch stall then R-type
    cyc(6'h00, 1'b0, e_fetch(1'b0, 1'b0), "r_fetch_wait0");
    cyc(6'h00, 1'b0, e_fetch(1'b0, 1'b0), "r_fetch_wait1");
    cyc(6'h00, 1'b1, e_fetch(1'b1, 1'b0), "r_fetch");
    cyc(6'h00, 1'b1, e_decode(1'b0),      "r_decode");
    cyc(6'h00, 1'b1, e_rexec(),           "r_exec");
    cyc(6'h00, 1'b1, e_rwb(),             "r_wb");

    // Immediate ALU operations
    for (int i = 0; i < 4; i++) begin
      cyc(iops[i], 1'b1, e_fetch(1'b1, 1'b0), "i_fetch");
      cyc(iops[i], 1'b1, e_decode(1'b0),      "i_decode");
      cyc(iops[i], 1'b1, e_iexec(ialu[i]),    "i_exec");
      cyc(iops[i], 1'b1, e_iwb(),             "i_wb");
    end

    // Jump
    cyc(6'h02, 1'b1, e_fetch(1'b1, 1'b0), "j_fetch");
    cyc(6'h02, 1'b1, e_decode(1'b0),      "j_decode");
    cyc(6'h02, 1'b1, e_jump(),            "j_jump");

    // Illegal opcode returns to FETCH with no strobes
    cyc(6'h3F, 1'b1, e_fetch(1'b1, 1'b0), "ill_fetch");
    cyc(6'h3F, 1'b1, e_decode(1'b1),      "ill_decode");

    // JAL, depending on build configuration
    cyc(6'h03, 1'b1, e_fetch(1'b1, 1'b0), "jal_fetch");
`ifdef MULTICYCLE_CONTROL_JAL_EN
    cyc(6'h03, 1'b1, e_decode(1'b0),      "jal_decode");
    cyc(6'h03, 1'b1, e_jalwb(),           "jal_wb");
`else
    cyc(6'h03, 1'b1, e_decode(1'b1),      "jal_decode_illegal");
`endif

    // LW with exactly MAX_WAIT waits, ready on the boundary cycle completes
    cyc(6'h23, 1'b1, e_fetch(1'b1, 1'b0), "lwb_fetch");
    cyc(6'h23, 1'b1, e_decode(1'b0),      "lwb_decode");
    cyc(6'h23, 1'b1, e_memaddr(),         "lwb_addr");
    for (int i = 0; i < 4; i++) cyc(6'h23, 1'b0, e_memrd(), "lwb_rd_wait");
    cyc(6'h23, 1'b1, e_memrd(),           "lwb_rd_boundary");
    cyc(6'h23, 1'b1, e_memwb(),           "lwb_wb");

    // Reset during a memory wait aborts the load
    cyc(6'h23, 1'b1, e_fetch(1'b1, 1'b0), "abort_fetch");
    cyc(6'h23, 1'b1, e_decode(1'b0),      "abort_decode");
    cyc(6'h23, 1'b1, e_memaddr(),         "abort_addr");
    cyc(6'h23, 1'b0, e_memrd(),           "abort_rd_wait");
    rcyc(1'b0, "abort_reset");
    cyc(6'h00, 1'b1, e_fetch(1'b1, 1'b0), "abort_refetch");
    cyc(6'h00, 1'b1, e_decode(1'b0),      "abort_decode2");
    cyc(6'h00, 1'b1, e_rexec(),           "abort_rexec");
    cyc(6'h00, 1'b1, e_rwb(),             "abort_rwb");

    // Fetch timeout: four tolerated waits, fifth times out, ERROR sticks
    for (int i = 0; i < 4; i++) cyc(6'h00, 1'b0, e_fetch(1'b0, 1'b0), "to_wait");
    cyc(6'h00, 1'b0, e_fetch(1'b0, 1'b1), "to_pulse");
    for (int i = 0; i < 3; i++) cyc(6'h00, 1'b1, e_error(), "to_error_hold");
    rcyc(1'b1, "to_reset");
    cyc(6'h02, 1'b1, e_fetch(1'b1, 1'b0), "to_refetch");
    cyc(6'h02, 1'b1, e_decode(1'b0),      "to_redecode");

    done = 1'b1;
    for (int i = 0; i < 10 && !drained; i++) @(negedge clk);
    #1;
    if (!drained) $display("FAIL drain: got pending expectations expected none");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + (drained ? 0 : 1));
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3: width of alu_op, minimum 3.
REQ-002 SHALL have parameter MAX_WAIT, default 15: memory wait cycles tolerated before timeout, range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port op, input, 6: opcode field of the instruction register.
REQ-006 SHALL have port mem_ready, input, 1: memory access completes this cycle.
REQ-007 SHALL have the following 1-bit outputs:
- pc_write, pc_write_eq, pc_write_ne, i_or_d
- mem_read, mem_write, ir_write, mem_to_reg
- reg_dst, reg_write, alu_src_a, link
REQ-008 SHALL have outputs alu_src_b and pc_source, 2 bits each.
REQ-009 SHALL have output alu_op, ALUOP_W bits: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 LUI, 7 R-type (funct decode).
REQ-010 SHALL have output state, 4 bits: current FSM state, for debug.
REQ-011 SHALL have outputs illegal_op and mem_timeout, 1 bit each.

Function
REQ-012 SHALL implement FSM states:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6
- R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JAL_WB=12, ERROR=15
REQ-013 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00, and ir_write=pc_write=mem_ready; it SHALL advance to DECODE only when mem_ready=1.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target) and SHALL dispatch on op:
- 0x00 -> R_EXEC
- 0x23/0x2B -> MEM_ADDR
- 0x08/0x0D/0x0C/0x0F -> I_EXEC
- 0x04/0x05 -> BRANCH
- 0x02 -> JUMP
- any other op -> FETCH, with illegal_op=1 for exactly that cycle
REQ-015 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=ADD; next state MEM_RD for 0x23, MEM_WR for 0x2B.
REQ-016 MEM_RD/MEM_WR SHALL drive i_or_d=1 and mem_read or mem_write respectively; each SHALL hold until mem_ready=1, then go to MEM_WB or FETCH.
REQ-017 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-018 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=7; R_WB SHALL drive reg_write=1, reg_dst=1; next FETCH.
REQ-019 I_EXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_op=ADD/OR/AND/LUI for 0x08/0x0D/0x0C/0x0F; I_WB SHALL drive reg_write=1, reg_dst=0.
REQ-020 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, with pc_write_eq=1 (0x04) or pc_write_ne=1 (0x05); next FETCH.
REQ-021 JUMP SHALL drive pc_write=1, pc_source=10; next FETCH.
REQ-022 Any output not listed for a state SHALL be 0.
REQ-023 The op value SHALL be latched on leaving DECODE, and later states SHALL use the latched value.
REQ-024 A wait counter SHALL count consecutive mem_ready=0 cycles in FETCH/MEM_RD/MEM_WR and clear on state change.
REQ-025 When the wait counter reaches MAX_WAIT with mem_ready still 0, mem_timeout SHALL pulse for 1 cycle and the FSM SHALL enter ERROR.
REQ-026 ERROR SHALL drive all control outputs to 0 and SHALL be left only by reset.
REQ-027 Simultaneous mem_ready=1 and counter==MAX_WAIT SHALL count as completion, not timeout.
REQ-028 Instruction latency SHALL be, with zero wait states: LW 5, SW 4, R/I 4, BEQ/BNE/J 3 cycles.

Reset
REQ-029 While reset=1, all outputs SHALL be 0; on the first edge with reset=1, state=FETCH and the wait counter, latched op and flags SHALL clear.
REQ-030 Reset asserted mid-instruction, including during a memory wait or in ERROR, SHALL abort it with no further write strobes.

Configuration
REQ-031 With macro MULTICYCLE_CONTROL_JAL_EN defined:
- op 0x03 in DECODE SHALL go to JAL_WB
- JAL_WB SHALL drive reg_write=1, link=1 (write PC to $31), pc_write=1, pc_source=10; next FETCH
REQ-032 Without MULTICYCLE_CONTROL_JAL_EN, op 0x03 SHALL be illegal per REQ-014, link SHALL be tied 0, and JAL_WB SHALL be unreachable.

Structure
REQ-033 Opcode constants, state encodings and alu_op codes SHALL reside in shared package mips_ctrl_pkg.
REQ-034 The wait counter and timeout SHALL be sub-module mem_wait_timer (parameter MAX_WAIT; inputs clk, reset, waiting, clear; output expired).

Verification
REQ-035 Scenario: op=0x23, mem_ready always 1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-036 Scenario: op=0x04, mem_ready=1 -> states 0,1,8,0; pc_write_eq=1 and alu_op=1 in state 8.
REQ-037 Scenario: op=0x2B, mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, then FETCH, no timeout.
REQ-038 Scenario: MAX_WAIT=4, mem_ready held 0 in FETCH -> mem_timeout pulses once, state=15 stays until reset, then state=0.
REQ-039 Scenario: op=0x3F -> illegal_op=1 for one cycle in DECODE, return to FETCH, no write strobes.
REQ-040 Scenario: op=0x03 -> with MULTICYCLE_CONTROL_JAL_EN, states 0,1,12,0 with link=1; without it, illegal_op=1.
